alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 4-bit ALU core (ALUCoreBehavioral). Two requesters each present operands and an opcode with a level request. The block grants the ALU round-robin, registers the operands onto the ALU inputs, and captures the sum and flags one cycle later. It returns the result to the granted requester with a one-cycle done pulse. It sits between the ALU core and its clients; the core stays purely combinational.

---
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port arbiter/sequencer for a combinational ALU core
// Ports: clk/rst_n (async active-low); req*/a*/b*/op* requester inputs;
// gnt*/done* one-cycle pulses; result/zero/overflow captured ALU outputs;
// busy = FSM not idle; alu_a/alu_b/alu_op registered ALU operands; alu_s/alu_zero/alu_ovf ALU outputs.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_zero,
  input  logic             alu_ovf
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  state_e state_q, state_d;
  // last_q doubles as the owner id: the last grant is always the in-flight owner
  logic last_q, last_d;
  logic fire, win1;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  logic zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0] alu_op_q, alu_op_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (req0 || req1) ? EXEC : IDLE;
      EXEC: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    fire     = state_q == IDLE && (req0 || req1);
    // requester 1 wins alone, or on a tie when requester 0 was granted last
    win1     = req1 && (!req0 || !last_q);
    gnt0_d   = fire && !win1;
    gnt1_d   = fire && win1;
    last_d   = fire ? win1 : last_q;
    alu_a_d  = fire ? (win1 ? a1 : a0) : alu_a_q;
    alu_b_d  = fire ? (win1 ? b1 : b0) : alu_b_q;
    alu_op_d = fire ? (win1 ? op1 : op0) : alu_op_q;
    done0_d  = state_q == EXEC && !last_q;
    done1_d  = state_q == EXEC && last_q;
    result_d = state_q == EXEC ? alu_s : result_q;
    zero_d   = state_q == EXEC ? alu_zero : zero_q;
    ovf_d    = state_q == EXEC ? alu_ovf : ovf_q;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = busy_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter with a stand-in ALU core
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n, req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic gnt0, gnt1, done0, done1, zero, overflow, busy;
  logic [3:0] result, alu_a, alu_b, alu_s;
  logic [1:0] alu_op;
  logic alu_zero, alu_ovf;
  int checks = 0;
  int failures = 0;
  int last_m = 1;
  alu_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );
  always #5 clk = ~clk;
  // stand-in for the combinational ALU core
  assign alu_s = alu_op[0] ? 4'(alu_a - alu_b) : 4'(alu_a + alu_b);
  assign alu_zero = alu_s == 4'd0;
  assign alu_ovf = alu_op[0] ? (alu_a[3] != alu_b[3] && alu_s[3] != alu_a[3])
                             : (alu_a[3] == alu_b[3] && alu_s[3] != alu_a[3]);
  // {overflow, zero, result} from signed integer arithmetic
  function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int sa, sb, r;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    r = op[0] ? sa - sb : sa + sb;
    ref_alu = {(r > 7 || r < -8), ((r & 15) == 0), 4'(r & 15)};
  endfunction
  // drives one transaction from an idle negedge; returns what was seen, leaves FSM idle
  task automatic txn(input logic [1:0] m, input logic [3:0] xa0, input logic [3:0] xb0, input logic [1:0] xo0,
                     input logic [3:0] xa1, input logic [3:0] xb1, input logic [1:0] xo1,
                     output logic [1:0] g, output logic [1:0] d, output logic [5:0] fr, output logic bz);
    req0 = m[0]; req1 = m[1];
    a0 = xa0; b0 = xb0; op0 = xo0; a1 = xa1; b1 = xb1; op1 = xo1;
    @(negedge clk);
    g = {gnt1, gnt0};
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    d = {done1, done0};
    fr = {overflow, zero, result};
    @(negedge clk);
    bz = busy;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, result, zero, overflow, alu_a, alu_b, alu_op} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 0", {gnt0, gnt1, done0, done1, busy, result, zero, overflow, alu_a, alu_b, alu_op});
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1;
  endtask
  task automatic test_single_add;
    logic [1:0] g, d; logic [5:0] fr; logic bz;
    txn(2'b01, 4'b0110, 4'b0111, 2'b00, 4'd0, 4'd0, 2'b00, g, d, fr, bz);
    last_m = 0;
    checks++;
    if (g !== 2'b01) begin failures++; $display("FAIL add_gnt got %b want 01", g); end
    checks++;
    if (d !== 2'b01) begin failures++; $display("FAIL add_done got %b want 01", d); end
    checks++;
    if (fr !== 6'b10_1101) begin failures++; $display("FAIL add_result got %b want 101101", fr); end
    checks++;
    if (bz !== 1'b0) begin failures++; $display("FAIL add_busy_after got %b want 0", bz); end
  endtask
  task automatic test_sub_zero;
    logic [1:0] g, d; logic [5:0] fr; logic bz;
    txn(2'b10, 4'd0, 4'd0, 2'b00, 4'b0011, 4'b0011, 2'b01, g, d, fr, bz);
    last_m = 1;
    checks++;
    if (g !== 2'b10) begin failures++; $display("FAIL sub_gnt got %b want 10", g); end
    checks++;
    if (d !== 2'b10) begin failures++; $display("FAIL sub_done got %b want 10", d); end
    checks++;
    if (fr !== 6'b01_0000) begin failures++; $display("FAIL sub_result got %b want 010000", fr); end
  endtask
  task automatic test_tie;
    logic [1:0] eg;
    rst_n = 1'b0;
    req0 = 1; a0 = 4'b0011; b0 = 4'b0010; op0 = 2'b01;
    req1 = 1; a1 = 4'b0101; b1 = 4'b0001; op1 = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      eg = ((i / 3) % 2) ? 2'b10 : 2'b01;
      checks++;
      if ({gnt1, gnt0} !== ((i % 3 == 0) ? eg : 2'b00)) begin
        failures++; $display("FAIL tie_gnt cycle %0d got %b want %b", i, {gnt1, gnt0}, (i % 3 == 0) ? eg : 2'b00);
      end
      checks++;
      if ({done1, done0} !== ((i % 3 == 1) ? eg : 2'b00)) begin
        failures++; $display("FAIL tie_done cycle %0d got %b want %b", i, {done1, done0}, (i % 3 == 1) ? eg : 2'b00);
      end
      checks++;
      if (busy !== (i % 3 != 2)) begin
        failures++; $display("FAIL tie_busy cycle %0d got %b want %b", i, busy, i % 3 != 2);
      end
      if (i % 3 == 1) begin
        checks++;
        if (result !== (eg[1] ? 4'b0110 : 4'b0001)) begin
          failures++; $display("FAIL tie_result cycle %0d got %b want %b", i, result, eg[1] ? 4'b0110 : 4'b0001);
        end
      end
      if (i == 11) begin req0 = 0; req1 = 0; end
    end
    last_m = 1;
  endtask
  task automatic test_operand_change;
    req0 = 1; a0 = 4'b0101; b0 = 4'b0010; op0 = 2'b00;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin failures++; $display("FAIL opchg_gnt got %b want 1", gnt0); end
    a0 = 4'b1111; req0 = 0;
    @(negedge clk);
    checks++;
    if ({done0, result, alu_a} !== {1'b1, 4'b0111, 4'b0101}) begin
      failures++; $display("FAIL opchg_result got done=%b res=%b alu_a=%b want 1 0111 0101", done0, result, alu_a);
    end
    @(negedge clk);
    last_m = 0;
  endtask
  task automatic test_reset_mid;
    logic [1:0] g, d; logic [5:0] fr; logic bz;
    req0 = 1; a0 = 4'b0001; b0 = 4'b0001; op0 = 2'b00;
    @(negedge clk);
    req0 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, result, zero, overflow, alu_a, alu_b, alu_op} !== 23'd0) begin
      failures++; $display("FAIL midrst_outputs got %b want 0", {gnt0, gnt1, done0, done1, busy, result, zero, overflow, alu_a, alu_b, alu_op});
    end
    @(negedge clk);
    checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      failures++; $display("FAIL midrst_nodone got %b want 000", {done0, done1, busy});
    end
    rst_n = 1'b1;
    last_m = 1;
    txn(2'b01, 4'b0010, 4'b0011, 2'b00, 4'd0, 4'd0, 2'b00, g, d, fr, bz);
    last_m = 0;
    checks++;
    if ({g, d, fr[3:0]} !== {2'b01, 2'b01, 4'b0101}) begin
      failures++; $display("FAIL midrst_after got %b want 01010101", {g, d, fr[3:0]});
    end
  endtask
  task automatic test_short_req;
    req0 = 1; a0 = 4'd1; b0 = 4'd1; op0 = 2'b00;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    req1 = 1;
    @(negedge clk);
    req1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt1, done1, busy} !== 3'b000) begin
        failures++; $display("FAIL short_req cycle %0d got %b want 000", i, {gnt1, done1, busy});
      end
    end
    last_m = 0;
  endtask
  task automatic test_random;
    logic [1:0] g, d, m, eg; logic [5:0] fr, ef; logic bz;
    logic [3:0] ra0, rb0, ra1, rb1; logic [1:0] ro0, ro1;
    for (int n = 0; n < 40; n++) begin
      m = 2'($urandom_range(1, 3));
      ra0 = 4'($urandom); rb0 = 4'($urandom); ro0 = {1'b0, 1'($urandom)};
      ra1 = 4'($urandom); rb1 = 4'($urandom); ro1 = {1'b0, 1'($urandom)};
      eg = (m == 2'b11) ? ((last_m == 1) ? 2'b01 : 2'b10) : m;
      last_m = eg[1] ? 1 : 0;
      ef = eg[1] ? ref_alu(ra1, rb1, ro1) : ref_alu(ra0, rb0, ro0);
      txn(m, ra0, rb0, ro0, ra1, rb1, ro1, g, d, fr, bz);
      checks++;
      if ({g, d, fr, bz} !== {eg, eg, ef, 1'b0}) begin
        failures++; $display("FAIL random_%0d got g=%b d=%b vzr=%b busy=%b want g=%b d=%b vzr=%b busy=0", n, g, d, fr, bz, eg, eg, ef);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single_add;
    test_sub_zero;
    test_tie;
    test_operand_change;
    test_reset_mid;
    test_short_req;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
